usb_cmd_regs: RTL and testbench
===============================

# usb_cmd_regs

Parametrised command register bank between the USB command decoder (`cmdvalid`/`cmd_addr`/`cmd_data`) and the ADC sampling core. It holds shadow and active copies of the configuration:
- channel mask
- sample count
- sample speed
- mode

It range-checks writes, commits shadows to the active registers on a start command, and issues one-cycle start/stop pulses. A run state machine supports single-shot and continuous re-arm operation. The block also provides registered readback and sticky error flags.

## Interface
Parameters:
- `CH_NUM`, 2, number of ADC channels (width of channel mask), 1..24
- `DEF_CH_SEL`, 1, reset channel mask
- `DEF_SAMPLE_NUM`, 16384, reset sample count
- `MAX_SAMPLE_NUM`, 65536, upper clamp for sample count (≥1)
- `DEF_SPEED`, 0, reset sample-speed divider

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `cmdvalid`  in  1  command strobe, one cycle per command
- `cmd_addr`  in  8  command register address
- `cmd_data`  in  32  command payload
- `rd_req`  in  1  readback request
- `rd_addr`  in  8  readback address
- `sample_done`  in  1  one-cycle pulse from sampling core: capture finished
- `adc_ch_sel`  out  CH_NUM  active channel mask
- `set_sample_num`  out  32  active sample count
- `set_sample_speed`  out  32  active speed divider
- `start_sample`  out  1  one-cycle start pulse
- `stop_sample`  out  1  one-cycle abort pulse
- `run_busy`  out  1  high while state is RUN
- `err_flags`  out  3  sticky errors: [0] bad address, [1] start while busy, [2] range
- `rd_valid`  out  1  readback data valid
- `rd_data`  out  32  readback data

## Operation
- Reset values:
  - Shadow and active registers: `ch` = `DEF_CH_SEL`, `num` = `DEF_SAMPLE_NUM`, `speed` = `DEF_SPEED`, `mode` = 0.
  - All pulses, `run_busy`, `err_flags`, `rd_valid` and `rd_data` are 0. State is IDLE.
- Command map (acted on only when `cmdvalid`=1):
  - 0: start. In IDLE: commit all shadows to active, pulse `start_sample`, go to RUN. In RUN: ignore and set err[1].
  - 1: shadow `ch` ← `cmd_data[CH_NUM-1:0]`. A zero mask leaves the shadow unchanged and sets err[2].
  - 2: shadow `num` ← `cmd_data`. Value 0 stores 1 and sets err[2]. Value > `MAX_SAMPLE_NUM` stores the max and sets err[2].
  - 3: shadow `speed` ← `cmd_data` (no check).
  - 4: combined write. Shadow `ch` ← `cmd_data[CH_NUM-1:0]` and shadow `num` ← zero-extended `cmd_data[31:8]`, both with the same checks as 1/2. Then start exactly as address 0, using the newly checked values in the commit.
  - 5: shadow `mode` ← `cmd_data[0]` (1 = continuous).
  - 6: stop. In RUN: pulse `stop_sample`, go to IDLE. In IDLE: no effect.
  - 7: err clear, write-1-to-clear on `cmd_data[2:0]`.
  - Others: set err[0].
- Run FSM:
  - IDLE → RUN on an accepted start.
  - RUN → on `sample_done`: if active `mode`=1, pulse `start_sample` and stay in RUN (active values unchanged); else go to IDLE.
  - RUN → IDLE on stop.
  - `sample_done` in IDLE is ignored.
- Shadow writes during RUN are allowed. They take effect only at the next accepted start.
- Readback addresses:
  - 0 → {27'b0, err_flags, state}. state occupies 2 bits: IDLE=0, RUN=1.
  - 1/2/3/5 → active value, zero-extended.
  - 8/9/10/13 → shadow copies of 1/2/3/5.
  - Others → 0 (no error).

## Timing
- All outputs are registered.
- Command at edge N → register/flag update and `start_sample`/`stop_sample` high during cycle N+1, for exactly one cycle.
- `sample_done` at edge N in continuous mode → `start_sample` high in cycle N+1.
- Simultaneous events:
  - Stop command and `sample_done` on the same edge: stop wins, no restart.
  - Start command and `sample_done` on the same edge, in RUN: `sample_done` is processed first, then the start is evaluated against the resulting state.
    - Single-shot mode: commit and a single `start_sample` pulse.
    - Continuous mode: one `start_sample` pulse and err[1] set.
- Error set and clear on the same edge: set wins.
- Readback: `rd_req` at edge N → `rd_valid`=1 with `rd_data` in cycle N+1. `rd_data` reflects register state before edge N's command. It holds until the next `rd_req`.
- Reset mid-run: immediate return to reset values; no pulse is emitted.

## Test plan
- Release reset, read addr 1/2/3 → 0x1, 16384, 0; `start_sample`=0, `err_flags`=0.
- Write addr2=1000, addr1=0x3, then addr0 → one-cycle `start_sample`, `set_sample_num`=1000, `adc_ch_sel`=2'b11, `run_busy`=1; `sample_done` → IDLE.
- Write addr2=0 → shadow num 1, err[2]=1. Write addr2=0x100000 → shadow num 65536. Write addr7 data 4 → err cleared.
- Write addr5=1, addr0, then 3 `sample_done` pulses → 4 `start_sample` pulses total. addr6 → `stop_sample` pulse, `run_busy`=0.
- Write addr4 data 0x0003E802 while IDLE → num 0x3E8, ch 2'b10, start pulse. Second addr0 while RUN → no pulse, err[1]=1. Write addr 0x55 → err[0]=1.
- Assert `reset_n`=0 mid-RUN with continuous mode → all outputs at reset values next cycle, no pulse after release.

Source files
------------

// File: rtl/usb_cmd_regs.sv
// usb_cmd_regs: shadow/active configuration bank for the ADC sampling core.
// Commands stage values into shadow registers. An accepted start copies the
// shadows into the active registers. A small run FSM generates start/stop
// pulses and re-arms in continuous mode. The bank also keeps sticky error
// flags and provides registered readback.
module usb_cmd_regs #(
  parameter int CH_NUM         = 2,
  parameter int DEF_CH_SEL     = 1,
  parameter int DEF_SAMPLE_NUM = 16384,
  parameter int MAX_SAMPLE_NUM = 65536,
  parameter int DEF_SPEED      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmdvalid,
  input  logic [7:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              rd_req,
  input  logic [7:0]        rd_addr,
  input  logic              sample_done,
  output logic [CH_NUM-1:0] adc_ch_sel,
  output logic [31:0]       set_sample_num,
  output logic [31:0]       set_sample_speed,
  output logic              start_sample,
  output logic              stop_sample,
  output logic              run_busy,
  output logic [2:0]        err_flags,
  output logic              rd_valid,
  output logic [31:0]       rd_data
);
  typedef enum logic [1:0] { ST_IDLE = 2'd0, ST_RUN = 2'd1 } state_t;

  localparam logic [CH_NUM-1:0] DEF_CH  = CH_NUM'(DEF_CH_SEL);
  localparam logic [31:0]       DEF_NUM = 32'(DEF_SAMPLE_NUM);
  localparam logic [31:0]       MAX_NUM = 32'(MAX_SAMPLE_NUM);
  localparam logic [31:0]       DEF_SPD = 32'(DEF_SPEED);

  state_t            state_reg, state_next;
  logic [CH_NUM-1:0] sh_ch_reg, sh_ch_next, act_ch_reg, act_ch_next;
  logic [31:0]       sh_num_reg, sh_num_next, act_num_reg, act_num_next;
  logic [31:0]       sh_speed_reg, sh_speed_next, act_speed_reg, act_speed_next;
  logic              sh_mode_reg, sh_mode_next, act_mode_reg, act_mode_next;
  logic              start_reg, start_next, stop_reg, stop_next;
  logic [2:0]        err_reg, err_next;
  logic              rd_valid_reg;
  logic [31:0]       rd_data_reg, rd_data_next;

  logic              do_start, do_stop, start_rej;
  logic [2:0]        err_set, err_clr;
  logic [31:0]       num_raw, num_chk;
  logic [CH_NUM-1:0] ch_raw;
  logic [31:0]       act_ch_ext, sh_ch_ext;

  // Zero-extend the channel masks to the 32-bit readback width.
  for (genvar gi = 0; gi < 32; gi++) begin : g_ch_ext
    if (gi < CH_NUM) begin : g_bit
      assign act_ch_ext[gi] = act_ch_reg[gi];
      assign sh_ch_ext[gi]  = sh_ch_reg[gi];
    end else begin : g_zero
      assign act_ch_ext[gi] = 1'b0;
      assign sh_ch_ext[gi]  = 1'b0;
    end
  end

  // Decode the command, range-check the payload and stage the shadow updates.
  always_comb begin
    sh_ch_next    = sh_ch_reg;
    sh_num_next   = sh_num_reg;
    sh_speed_next = sh_speed_reg;
    sh_mode_next  = sh_mode_reg;
    do_start      = 1'b0;
    do_stop       = 1'b0;
    err_set       = 3'b000;
    err_clr       = 3'b000;
    ch_raw        = cmd_data[CH_NUM-1:0];
    // The combined write carries the sample count in the upper 24 bits.
    num_raw       = (cmd_addr == 8'd4) ? {8'd0, cmd_data[31:8]} : cmd_data;
    if (num_raw == 32'd0)        num_chk = 32'd1;
    else if (num_raw > MAX_NUM)  num_chk = MAX_NUM;
    else                         num_chk = num_raw;
    if (cmdvalid) begin
      case (cmd_addr)
        8'd0: do_start = 1'b1;
        8'd1, 8'd4: begin
          if (ch_raw == '0) err_set[2] = 1'b1;
          else              sh_ch_next = ch_raw;
          if (cmd_addr == 8'd4) begin
            sh_num_next = num_chk;
            if (num_raw == 32'd0 || num_raw > MAX_NUM) err_set[2] = 1'b1;
            do_start = 1'b1;
          end
        end
        8'd2: begin
          sh_num_next = num_chk;
          if (num_raw == 32'd0 || num_raw > MAX_NUM) err_set[2] = 1'b1;
        end
        8'd3: sh_speed_next = cmd_data;
        8'd5: sh_mode_next  = cmd_data[0];
        8'd6: do_stop       = 1'b1;
        8'd7: err_clr       = cmd_data[2:0];
        default: err_set[0] = 1'b1;
      endcase
    end
  end

  // Run FSM: stop beats sample_done, and sample_done is resolved before a start.
  always_comb begin
    state_next     = state_reg;
    act_ch_next    = act_ch_reg;
    act_num_next   = act_num_reg;
    act_speed_next = act_speed_reg;
    act_mode_next  = act_mode_reg;
    start_next     = 1'b0;
    stop_next      = 1'b0;
    start_rej      = 1'b0;
    if (state_reg == ST_RUN && do_stop) begin
      stop_next  = 1'b1;
      state_next = ST_IDLE;
    end else begin
      if (state_reg == ST_RUN && sample_done) begin
        if (act_mode_reg) start_next = 1'b1;
        else              state_next = ST_IDLE;
      end
      if (do_start) begin
        if (state_next == ST_IDLE) begin
          // Commit uses the freshly checked shadows so a combined write starts with its own values.
          act_ch_next    = sh_ch_next;
          act_num_next   = sh_num_next;
          act_speed_next = sh_speed_next;
          act_mode_next  = sh_mode_next;
          start_next     = 1'b1;
          state_next     = ST_RUN;
        end else begin
          start_rej = 1'b1;
        end
      end
    end
    // A set on the same edge as a clear wins.
    err_next = (err_reg & ~err_clr) | err_set | {1'b0, start_rej, 1'b0};
  end

  // Readback mux reflects the register state before this edge's command.
  always_comb begin
    rd_data_next = rd_data_reg;
    if (rd_req) begin
      case (rd_addr)
        8'd0:    rd_data_next = {27'd0, err_reg, state_reg};
        8'd1:    rd_data_next = act_ch_ext;
        8'd2:    rd_data_next = act_num_reg;
        8'd3:    rd_data_next = act_speed_reg;
        8'd5:    rd_data_next = {31'd0, act_mode_reg};
        8'd8:    rd_data_next = sh_ch_ext;
        8'd9:    rd_data_next = sh_num_reg;
        8'd10:   rd_data_next = sh_speed_reg;
        8'd13:   rd_data_next = {31'd0, sh_mode_reg};
        default: rd_data_next = 32'd0;
      endcase
    end
  end

  // State, configuration, pulse, error and readback registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      sh_ch_reg     <= DEF_CH;
      act_ch_reg    <= DEF_CH;
      sh_num_reg    <= DEF_NUM;
      act_num_reg   <= DEF_NUM;
      sh_speed_reg  <= DEF_SPD;
      act_speed_reg <= DEF_SPD;
      sh_mode_reg   <= 1'b0;
      act_mode_reg  <= 1'b0;
      start_reg     <= 1'b0;
      stop_reg      <= 1'b0;
      err_reg       <= 3'b000;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      sh_ch_reg     <= sh_ch_next;
      act_ch_reg    <= act_ch_next;
      sh_num_reg    <= sh_num_next;
      act_num_reg   <= act_num_next;
      sh_speed_reg  <= sh_speed_next;
      act_speed_reg <= act_speed_next;
      sh_mode_reg   <= sh_mode_next;
      act_mode_reg  <= act_mode_next;
      start_reg     <= start_next;
      stop_reg      <= stop_next;
      err_reg       <= err_next;
      rd_valid_reg  <= rd_req;
      rd_data_reg   <= rd_data_next;
    end
  end

  assign adc_ch_sel       = act_ch_reg;
  assign set_sample_num   = act_num_reg;
  assign set_sample_speed = act_speed_reg;
  assign start_sample     = start_reg;
  assign stop_sample      = stop_reg;
  assign run_busy         = (state_reg == ST_RUN);
  assign err_flags        = err_reg;
  assign rd_valid         = rd_valid_reg;
  assign rd_data          = rd_data_reg;
endmodule

// File: tb/tb_usb_cmd_regs.sv
// tb_usb_cmd_regs: directed stimulus for usb_cmd_regs. A behavioural model
// is checked against the DUT on every cycle, and hand-computed literal
// expectations are checked at key points.
module tb_usb_cmd_regs;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmdvalid = 1'b0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_addr = 8'd0;
  logic        sample_done = 1'b0;
  logic [1:0]  adc_ch_sel;
  logic [31:0] set_sample_num, set_sample_speed, rd_data;
  logic        start_sample, stop_sample, run_busy, rd_valid;
  logic [2:0]  err_flags;

  usb_cmd_regs dut (
    .clk(clk), .reset_n(reset_n), .cmdvalid(cmdvalid), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .sample_done(sample_done), .adc_ch_sel(adc_ch_sel),
    .set_sample_num(set_sample_num), .set_sample_speed(set_sample_speed),
    .start_sample(start_sample), .stop_sample(stop_sample),
    .run_busy(run_busy), .err_flags(err_flags), .rd_valid(rd_valid),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: configuration as plain variables, busy flag, event order.
  logic [1:0]  m_sh_ch, m_a_ch;
  logic [31:0] m_sh_num, m_a_num, m_sh_spd, m_a_spd, m_rd, m_v;
  logic        m_sh_mode, m_a_mode, m_busy, m_start, m_stop, m_rv;
  logic [2:0]  m_err;
  bit          m_is_start, m_is_stop;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'd0:  return {27'd0, m_err, 1'b0, m_busy};
      8'd1:  return {30'd0, m_a_ch};
      8'd2:  return m_a_num;
      8'd3:  return m_a_spd;
      8'd5:  return {31'd0, m_a_mode};
      8'd8:  return {30'd0, m_sh_ch};
      8'd9:  return m_sh_num;
      8'd10: return m_sh_spd;
      8'd13: return {31'd0, m_sh_mode};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sh_ch = 2'd1; m_a_ch = 2'd1; m_sh_num = 16384; m_a_num = 16384;
      m_sh_spd = 0; m_a_spd = 0; m_sh_mode = 0; m_a_mode = 0;
      m_busy = 0; m_start = 0; m_stop = 0; m_rv = 0; m_rd = 0; m_err = 0;
    end else begin
      m_start = 0; m_stop = 0;
      m_rv = rd_req;
      if (rd_req) m_rd = model_read(rd_addr);
      m_is_start = cmdvalid && (cmd_addr == 8'd0 || cmd_addr == 8'd4);
      m_is_stop  = cmdvalid && (cmd_addr == 8'd6);
      if (cmdvalid) begin
        if (cmd_addr == 8'd1 || cmd_addr == 8'd4) begin
          if (cmd_data[1:0] == 2'd0) m_err[2] = 1'b1;
          else m_sh_ch = cmd_data[1:0];
        end
        if (cmd_addr == 8'd2 || cmd_addr == 8'd4) begin
          m_v = (cmd_addr == 8'd4) ? (cmd_data >> 8) : cmd_data;
          if (m_v == 0)          begin m_sh_num = 1;     m_err[2] = 1'b1; end
          else if (m_v > 65536)  begin m_sh_num = 65536; m_err[2] = 1'b1; end
          else m_sh_num = m_v;
        end
        if (cmd_addr == 8'd3) m_sh_spd = cmd_data;
        if (cmd_addr == 8'd5) m_sh_mode = cmd_data[0];
        if (cmd_addr == 8'd7) m_err = m_err & ~cmd_data[2:0];
        if (cmd_addr > 8'd7)  m_err[0] = 1'b1;
      end
      if (m_busy && m_is_stop) begin
        m_stop = 1; m_busy = 0;
      end else begin
        if (m_busy && sample_done) begin
          if (m_a_mode) m_start = 1; else m_busy = 0;
        end
        if (m_is_start) begin
          if (!m_busy) begin
            m_a_ch = m_sh_ch; m_a_num = m_sh_num; m_a_spd = m_sh_spd; m_a_mode = m_sh_mode;
            m_start = 1; m_busy = 1;
          end else m_err[1] = 1'b1;
        end
      end
    end
  end

  // Literal expectations are queued by the stimulus and checked by the compare process.
  string       lit_name [0:255];
  logic [31:0] lit_act  [0:255];
  logic [31:0] lit_exp  [0:255];
  int          lit_wr = 0;
  int          lit_rd = 0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model every cycle, then drain literal checks.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("adc_ch_sel", 32'(adc_ch_sel), 32'(m_a_ch));
      chk("set_sample_num", set_sample_num, m_a_num);
      chk("set_sample_speed", set_sample_speed, m_a_spd);
      chk("start_sample", 32'(start_sample), 32'(m_start));
      chk("stop_sample", 32'(stop_sample), 32'(m_stop));
      chk("run_busy", 32'(run_busy), 32'(m_busy));
      chk("err_flags", 32'(err_flags), 32'(m_err));
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("rd_data", rd_data, m_rd);
      if (start_sample) start_cnt++;
    end
    while (lit_rd < lit_wr) begin
      chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_name[lit_wr] = nm; lit_act[lit_wr] = act; lit_exp[lit_wr] = exp;
    lit_wr++;
  endtask

  task automatic step(input logic cv, input logic [7:0] a, input logic [31:0] d,
                      input logic rq, input logic [7:0] ra, input logic done);
    cmdvalid = cv; cmd_addr = a; cmd_data = d; rd_req = rq; rd_addr = ra; sample_done = done;
    $display("cycle t=%0t cv=%0d addr=0x%0h data=0x%0h rd=%0d raddr=%0d done=%0d",
             $time, cv, a, d, rq, ra, done);
    @(negedge clk);
    cmdvalid = 1'b0; rd_req = 1'b0; sample_done = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] ra);
    step(1'b0, 8'd0, 32'd0, 1'b1, ra, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b0);
  endtask

  int base;

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    // Reset values through readback.
    rd(8'd1);  lit("rst_rd_ch", rd_data, 32'd1); lit("rst_rd_valid", 32'(rd_valid), 32'd1);
    rd(8'd2);  lit("rst_rd_num", rd_data, 32'd16384);
    rd(8'd3);  lit("rst_rd_speed", rd_data, 32'd0);
    lit("rst_start", 32'(start_sample), 32'd0); lit("rst_err", 32'(err_flags), 32'd0);
    // Basic configure and start.
    cmd(8'd2, 32'd1000); cmd(8'd1, 32'd3); cmd(8'd0, 32'd0);
    lit("go_start", 32'(start_sample), 32'd1); lit("go_num", set_sample_num, 32'd1000);
    lit("go_ch", 32'(adc_ch_sel), 32'd3); lit("go_busy", 32'(run_busy), 32'd1);
    lit("model_a_num", m_a_num, 32'd1000);
    rd(8'd0);  lit("go_rd_state", rd_data, 32'd1); lit("go_start_1cyc", 32'(start_sample), 32'd0);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1); lit("done_idle", 32'(run_busy), 32'd0);
    // Range checks on the sample count and channel mask.
    cmd(8'd2, 32'd0);        lit("num0_err", 32'(err_flags), 32'd4);
    rd(8'd9);                lit("num0_sh", rd_data, 32'd1);
    cmd(8'd2, 32'h100000);   rd(8'd9); lit("numbig_sh", rd_data, 32'd65536);
    cmd(8'd7, 32'd4);        lit("err_clr", 32'(err_flags), 32'd0);
    cmd(8'd2, 32'd65536);    lit("nummax_ok", 32'(err_flags), 32'd0);
    cmd(8'd2, 32'd65537);    lit("nummax1_err", 32'(err_flags), 32'd4);
    cmd(8'd7, 32'd7);        cmd(8'd1, 32'd0); lit("ch0_err", 32'(err_flags), 32'd4);
    rd(8'd8);                lit("ch0_keep", rd_data, 32'd3);
    cmd(8'd7, 32'd7); cmd(8'd2, 32'd1000); cmd(8'd3, 32'd7);
    rd(8'd2);                lit("shadow_not_active", rd_data, 32'd1000);
    // Continuous mode re-arm.
    cmd(8'd5, 32'd1);
    base = start_cnt;
    cmd(8'd0, 32'd0);        lit("cont_speed", set_sample_speed, 32'd7);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1); lit("cont_rearm", 32'(start_sample), 32'd1);
    idle(1);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1); idle(1);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1); idle(1);
    lit("cont_pulses", 32'(start_cnt - base), 32'd4); lit("cont_busy", 32'(run_busy), 32'd1);
    cmd(8'd6, 32'd0);        lit("stop_pulse", 32'(stop_sample), 32'd1);
    lit("stop_busy", 32'(run_busy), 32'd0);
    // Combined write, start while busy, bad address.
    cmd(8'd4, 32'h0003E802);
    lit("comb_num", set_sample_num, 32'h3E8); lit("comb_ch", 32'(adc_ch_sel), 32'd2);
    lit("comb_start", 32'(start_sample), 32'd1);
    cmd(8'd0, 32'd0);        lit("busy_start", 32'(start_sample), 32'd0);
    lit("busy_err", 32'(err_flags), 32'd2);
    cmd(8'h55, 32'd0);       lit("badaddr_err", 32'(err_flags), 32'd3);
    rd(8'd0);                lit("rd_status", rd_data, 32'd13);
    // Simultaneous events.
    step(1'b1, 8'd6, 32'd0, 1'b0, 8'd0, 1'b1);
    lit("stopdone_stop", 32'(stop_sample), 32'd1); lit("stopdone_start", 32'(start_sample), 32'd0);
    lit("stopdone_busy", 32'(run_busy), 32'd0);
    cmd(8'd7, 32'd7); cmd(8'd0, 32'd0);
    step(1'b1, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1);
    lit("contdone_start", 32'(start_sample), 32'd1); lit("contdone_err", 32'(err_flags), 32'd2);
    cmd(8'd5, 32'd0); cmd(8'd6, 32'd0); cmd(8'd0, 32'd0); cmd(8'd7, 32'd7);
    step(1'b1, 8'd4, 32'h00000501, 1'b0, 8'd0, 1'b1);
    lit("ssdone_start", 32'(start_sample), 32'd1); lit("ssdone_num", set_sample_num, 32'd5);
    lit("ssdone_ch", 32'(adc_ch_sel), 32'd1); lit("ssdone_err", 32'(err_flags), 32'd0);
    lit("ssdone_busy", 32'(run_busy), 32'd1);
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1);
    // Asynchronous reset in the middle of a continuous run.
    cmd(8'd5, 32'd1); cmd(8'd0, 32'd0);
    rd(8'd3);                lit("pre_rst_rd", rd_data, 32'd7);
    #3 reset_n = 1'b0;
    @(negedge clk);
    lit("mid_rst_busy", 32'(run_busy), 32'd0); lit("mid_rst_ch", 32'(adc_ch_sel), 32'd1);
    lit("mid_rst_num", set_sample_num, 32'd16384); lit("mid_rst_spd", set_sample_speed, 32'd0);
    lit("mid_rst_err", 32'(err_flags), 32'd0); lit("mid_rst_rd", rd_data, 32'd0);
    lit("mid_rst_start", 32'(start_sample), 32'd0);
    reset_n = 1'b1;
    base = start_cnt;
    step(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 1'b1);
    idle(3);
    lit("post_rst_pulses", 32'(start_cnt - base), 32'd0);
    lit("post_rst_busy", 32'(run_busy), 32'd0);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
